// File: rtl/add_nibble_sched_if.sv
// add_nibble_sched_if
// Request/grant/result bundle for the two-requester serial nibble adder.
//   req0/a0/b0/cin0 : requester 0 add request and operands
//   req1/a1/b1/cin1 : requester 1 add request and operands
//   gnt0/gnt1       : one-cycle grant pulses
//   busy            : an operation is in progress
//   done            : one-cycle result-valid pulse
//   owner           : requester index that owns sum/cout
//   sum/cout        : registered result
// Modports: master drives requests and operands, slave is the adder.
interface add_nibble_sched_if #(
    parameter int NIB = 4
);
    localparam int W = 4 * NIB;

    logic         req0;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic         cin0;
    logic         req1;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         cin1;
    logic         gnt0;
    logic         gnt1;
    logic         busy;
    logic         done;
    logic         owner;
    logic [W-1:0] sum;
    logic         cout;

    modport master (
        output req0, a0, b0, cin0, req1, a1, b1, cin1,
        input  gnt0, gnt1, busy, done, owner, sum, cout
    );

    modport slave (
        input  req0, a0, b0, cin0, req1, a1, b1, cin1,
        output gnt0, gnt1, busy, done, owner, sum, cout
    );
endinterface

// File: rtl/add_nibble_sched.sv
// add_nibble_sched
// Two-requester round-robin scheduler in front of a serial adder that
// computes {cout,sum} = a + b + cin through one 4-bit slice, LSB nibble first.
// Ports:
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset
//   bus : add_nibble_sched_if.slave (requests, operands, grants, result)
module add_nibble_sched #(
    parameter int NIB = 4
) (
    input logic                clk,
    input logic                rst,
    add_nibble_sched_if.slave  bus
);
    localparam int W  = 4 * NIB;
    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state;
    state_t        state_nx;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_w;
    logic [W-1:0]  b_w;
    logic [W-1:0]  res_w;
    logic          c_w;
    logic          own_w;
    logic          last;      // requester served most recently
    logic          accept;
    logic          win;
    logic          last_nib;
    logic [4:0]    slice;
    logic [W-1:0]  res_nx;

    function automatic logic [4:0] add_slice(input logic [3:0] x,
                                             input logic [3:0] y,
                                             input logic       c);
        return {1'b0, x} + {1'b0, y} + {4'b0000, c};
    endfunction

    // Tie goes to the requester that was not served last.
    always_comb begin
        accept   = (state == IDLE) && (bus.req0 || bus.req1);
        win      = (bus.req0 && bus.req1) ? ~last : bus.req1;
        last_nib = (idx == IW'(NIB - 1));
        slice    = add_slice(a_w[3:0], b_w[3:0], c_w);
        // Result nibbles enter at the top and shift down, so after NIB
        // slices nibble 0 sits at the LSBs.
        res_nx   = (res_w >> 4) | (W'(slice[3:0]) << (W - 4));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)   state_nx = RUN;
            RUN:     if (last_nib) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            a_w       <= '0;
            b_w       <= '0;
            res_w     <= '0;
            c_w       <= 1'b0;
            own_w     <= 1'b0;
            last      <= 1'b1;
            bus.gnt0  <= 1'b0;
            bus.gnt1  <= 1'b0;
            bus.done  <= 1'b0;
            bus.owner <= 1'b0;
            bus.sum   <= '0;
            bus.cout  <= 1'b0;
        end else begin
            bus.gnt0 <= 1'b0;
            bus.gnt1 <= 1'b0;
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_w      <= win ? bus.a1   : bus.a0;
                        b_w      <= win ? bus.b1   : bus.b0;
                        c_w      <= win ? bus.cin1 : bus.cin0;
                        own_w    <= win;
                        last     <= win;
                        idx      <= '0;
                        res_w    <= '0;
                        bus.gnt0 <= ~win;
                        bus.gnt1 <= win;
                    end
                end
                RUN: begin
                    a_w   <= a_w >> 4;
                    b_w   <= b_w >> 4;
                    c_w   <= slice[4];
                    res_w <= res_nx;
                    idx   <= idx + IW'(1);
                    if (last_nib) begin
                        idx       <= '0;
                        bus.sum   <= res_nx;
                        bus.cout  <= slice[4];
                        bus.owner <= own_w;
                        bus.done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_add_nibble_sched.sv
// tb_add_nibble_sched
// Directed and randomized bench for add_nibble_sched; expected results come
// from plain (W+1)-bit addition and a served-last round-robin model.
module tb_add_nibble_sched;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;
    localparam int VW  = W + 1;

    logic clk;
    logic rst;
    int   vecs;
    int   errs;
    logic last_srv;

    add_nibble_sched_if #(.NIB(NIB)) bus ();

    add_nibble_sched #(.NIB(NIB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic check_b(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_v(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_b("gnt_exclusive", (bus.gnt0 & bus.gnt1) | ((bus.gnt0 | bus.gnt1) & bus.done), 1'b0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        step();
        step();
        rst = 1'b0;
        last_srv = 1'b1;
    endtask

    function automatic logic [VW-1:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    task automatic run_op(input string tag, input logic r0, input logic r1,
                          input logic [W-1:0] x0, input logic [W-1:0] y0, input logic z0,
                          input logic [W-1:0] x1, input logic [W-1:0] y1, input logic z1,
                          input bit perturb);
        logic          exp_w;
        logic [VW-1:0] exp_r;
        logic          got;
        bus.a0 = x0; bus.b0 = y0; bus.cin0 = z0;
        bus.a1 = x1; bus.b1 = y1; bus.cin1 = z1;
        bus.req0 = r0; bus.req1 = r1;
        exp_w = (r0 && r1) ? ~last_srv : r1;
        exp_r = exp_w ? model_add(x1, y1, z1) : model_add(x0, y0, z0);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            got = bus.gnt0 | bus.gnt1;
        end
        check_b({tag, "_gnt_seen"}, got, 1'b1);
        if (!got) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
            return;
        end
        check_b({tag, "_gnt0"}, bus.gnt0, ~exp_w);
        check_b({tag, "_gnt1"}, bus.gnt1, exp_w);
        check_b({tag, "_busy_gnt"}, bus.busy, 1'b1);
        last_srv = exp_w;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        if (perturb) begin
            bus.a0 = W'($urandom); bus.b0 = W'($urandom); bus.cin0 = ~bus.cin0;
            bus.a1 = W'($urandom); bus.b1 = W'($urandom); bus.cin1 = ~bus.cin1;
        end
        for (int k = 2; k <= NIB; k++) begin
            step();
            check_b({tag, "_busy_run"}, bus.busy, 1'b1);
            check_b({tag, "_done_early"}, bus.done, 1'b0);
        end
        step();
        check_b({tag, "_done"}, bus.done, 1'b1);
        check_b({tag, "_busy_end"}, bus.busy, 1'b0);
        check_v({tag, "_result"}, {bus.cout, bus.sum}, exp_r);
        check_b({tag, "_owner"}, bus.owner, exp_w);
        step();
        check_b({tag, "_done_pulse"}, bus.done, 1'b0);
        check_b({tag, "_no_regrant"}, bus.gnt0 | bus.gnt1, 1'b0);
        check_v({tag, "_hold"}, {bus.cout, bus.sum}, exp_r);
    endtask

    initial begin
        int          n;
        int          cyc;
        int          prev;
        logic        expw;
        logic [1:0]  pat;

        vecs = 0;
        errs = 0;
        last_srv = 1'b1;
        rst = 1'b1;
        bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0; bus.cin0 = 1'b0;
        bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0; bus.cin1 = 1'b0;

        // Reset state
        step();
        step();
        check_b("rst_gnt0", bus.gnt0, 1'b0);
        check_b("rst_gnt1", bus.gnt1, 1'b0);
        check_b("rst_busy", bus.busy, 1'b0);
        check_b("rst_done", bus.done, 1'b0);
        check_b("rst_owner", bus.owner, 1'b0);
        check_v("rst_result", {bus.cout, bus.sum}, '0);
        rst = 1'b0;
        step();

        run_op("basic", 1'b1, 1'b0, 16'h1234, 16'h4321, 1'b0, '0, '0, 1'b0, 1'b0);
        run_op("ripple", 1'b0, 1'b1, '0, '0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        run_op("sample", 1'b1, 1'b0, 16'h0ABC, 16'h1111, 1'b1, '0, '0, 1'b0, 1'b1);

        // Simultaneous requests right after reset
        reset_dut();
        bus.a0 = 16'h000F; bus.b0 = 16'h0001; bus.cin0 = 1'b0;
        bus.a1 = 16'h8000; bus.b1 = 16'h8000; bus.cin1 = 1'b0;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        step();
        check_b("tie_gnt0", bus.gnt0, 1'b1);
        check_b("tie_gnt1", bus.gnt1, 1'b0);
        bus.req0 = 1'b0;
        for (int k = 0; k < NIB; k++) step();
        check_b("tie_done0", bus.done, 1'b1);
        check_v("tie_res0", {bus.cout, bus.sum}, 17'h00010);
        check_b("tie_owner0", bus.owner, 1'b0);
        step();
        check_b("tie_gnt1_after5", bus.gnt1, 1'b1);
        bus.req1 = 1'b0;
        for (int k = 0; k < NIB; k++) step();
        check_b("tie_done1", bus.done, 1'b1);
        check_v("tie_res1", {bus.cout, bus.sum}, 17'h10000);
        check_b("tie_owner1", bus.owner, 1'b1);
        last_srv = 1'b1;
        step();

        // Both requests held for eight grants
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        n = 0; cyc = 0; prev = 0;
        expw = ~last_srv;
        for (int c = 0; c < 80 && n < 8; c++) begin
            step();
            cyc++;
            if (bus.gnt0 | bus.gnt1) begin
                check_b("rr_gnt0", bus.gnt0, ~expw);
                check_b("rr_gnt1", bus.gnt1, expw);
                if (n > 0) check_v("rr_spacing", VW'(cyc - prev), VW'(NIB + 1));
                prev = cyc;
                n++;
                last_srv = expw;
                expw = ~expw;
            end
        end
        check_v("rr_count", VW'(n), VW'(8));
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        for (int k = 0; k < NIB + 1; k++) step();

        // Reset while nibble 2 is being processed, with a request at the same edge
        bus.a0 = 16'h1234; bus.b0 = 16'h1111; bus.cin0 = 1'b0;
        bus.req0 = 1'b1; bus.req1 = 1'b0;
        expw = (bus.req0 && bus.req1) ? ~last_srv : 1'b0;
        step();
        check_b("abort_gnt0", bus.gnt0, ~expw);
        bus.req0 = 1'b0;
        step();
        step();
        rst = 1'b1;
        bus.req0 = 1'b1;
        step();
        check_b("abort_gnt0_rst", bus.gnt0, 1'b0);
        check_b("abort_gnt1_rst", bus.gnt1, 1'b0);
        check_b("abort_busy", bus.busy, 1'b0);
        check_b("abort_done", bus.done, 1'b0);
        check_b("abort_owner", bus.owner, 1'b0);
        check_v("abort_result", {bus.cout, bus.sum}, '0);
        bus.req0 = 1'b0;
        rst = 1'b0;
        last_srv = 1'b1;
        for (int k = 0; k < NIB + 2; k++) begin
            step();
            check_b("abort_no_done", bus.done, 1'b0);
        end
        run_op("post_abort", 1'b1, 1'b0, 16'h0001, 16'h0001, 1'b0, '0, '0, 1'b0, 1'b0);

        // Randomized operations
        for (int t = 0; t < 24; t++) begin
            pat = 2'($urandom_range(1, 3));
            run_op("rand", pat[0], pat[1],
                   W'($urandom), W'($urandom), 1'($urandom),
                   W'($urandom), W'($urandom), 1'($urandom),
                   1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
